// File: rtl/sdram_arbiter.sv
// Two-port fixed-priority arbiter (port 0 high) with a starvation limit for port 1,
// sequencing one SDRAM controller transaction at a time. Define SDRAM_ARB_STATS_EN for stats outputs.
module sdram_arbiter #(
    parameter int ADDR_WIDTH   = 24,
    parameter int DATA_WIDTH   = 16,
    parameter int BURST_LENGTH = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_wnext,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_rvalid,
    output logic                  p0_done,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_wnext,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_rvalid,
    output logic                  p1_done,
    output logic [1:0]            mem_command,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_read_valid,
    input  logic                  mem_write_done
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [31:0]           p0_txn_count,
    output logic [31:0]           p1_txn_count,
    output logic                  starve_hit
`endif
);

    localparam int BW = $clog2(BURST_LENGTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST_LENGTH - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t          state;
    logic            gnt0;
    logic            gnt1;
    logic            cur_we;
    logic [BW-1:0]   beat_cnt;
    logic [SW-1:0]   starve_cnt;
    logic            pick1;
    logic            beat;

    always_comb begin
        pick1          = p1_req & (~p0_req | (starve_cnt == STARVE_MAX));
        beat           = cur_we ? mem_write_done : mem_read_valid;
        mem_write_data = gnt1 ? p1_wdata : (gnt0 ? p0_wdata : '0);
        p0_wnext       = mem_write_done & gnt0 & cur_we;
        p1_wnext       = mem_write_done & gnt1 & cur_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            cur_we      <= 1'b0;
            beat_cnt    <= '0;
            starve_cnt  <= '0;
            mem_command <= 2'd0;
            mem_address <= '0;
            p0_done     <= 1'b0;
            p1_done     <= 1'b0;
            p0_rvalid   <= 1'b0;
            p1_rvalid   <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
        end else begin
            p0_done   <= 1'b0;
            p1_done   <= 1'b0;
            p0_rvalid <= mem_read_valid & gnt0;
            p1_rvalid <= mem_read_valid & gnt1;
            p0_rdata  <= (mem_read_valid & gnt0) ? mem_read_data : '0;
            p1_rdata  <= (mem_read_valid & gnt1) ? mem_read_data : '0;
            case (state)
                IDLE: begin
                    if (p0_req | p1_req) begin
                        gnt0        <= ~pick1;
                        gnt1        <= pick1;
                        cur_we      <= pick1 ? p1_we : p0_we;
                        mem_command <= (pick1 ? p1_we : p0_we) ? 2'd1 : 2'd2;
                        mem_address <= pick1 ? p1_addr : p0_addr;
                        beat_cnt    <= '0;
                        if (pick1)
                            starve_cnt <= '0;
                        else if (p1_req && starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Drop the command on the final beat so the controller sees idle before it re-arms.
                    if (beat) begin
                        if (beat_cnt == LAST_BEAT) begin
                            mem_command <= 2'd0;
                            p0_done     <= gnt0;
                            p1_done     <= gnt1;
                            gnt0        <= 1'b0;
                            gnt1        <= 1'b0;
                            beat_cnt    <= '0;
                            state       <= GAP;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_txn_count <= '0;
            p1_txn_count <= '0;
            starve_hit   <= 1'b0;
        end else begin
            if (p0_done)
                p0_txn_count <= p0_txn_count + 32'd1;
            if (p1_done)
                p1_txn_count <= p1_txn_count + 32'd1;
            // Port 1 beating a live port-0 request can only happen through the limit.
            if (state == IDLE && pick1 && p0_req)
                starve_hit <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized scoreboard bench for sdram_arbiter: behavioural controller, requesters,
// and a reference arbitration/memory model predicting grants, read data and write data.
module tb_sdram_arbiter;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int BL = 4;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic p0_req, p0_we, p0_wnext, p0_rvalid, p0_done;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic p1_req, p1_we, p1_wnext, p1_rvalid, p1_done;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic [1:0] mem_command;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data, mem_read_data;
    logic mem_read_valid, mem_write_done;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH(BL), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wnext(p0_wnext), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid), .p0_done(p0_done),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wnext(p1_wnext), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid), .p1_done(p1_done),
        .mem_command(mem_command), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid), .mem_write_done(mem_write_done)
    );

    typedef struct packed {
        logic                  we;
        logic [AW-1:0]         addr;
        logic [BL-1:0][DW-1:0] data;
    } txn_t;

    int total = 0;
    int bad = 0;

    txn_t cur[2];
    bit   active[2];
    int   widx[2];
    bit   wadv[2];
    int   gen_left[2];
    int   gen_prob[2];

    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] ctl_mem [logic [AW-1:0]];
    logic [DW-1:0] rd_q[2][$];
    logic [DW-1:0] wr_q[2][$];
    int grant_log[$];

    int starve_m = 0;
    bit ctl_busy = 0;
    bit ctl_we;
    int ctl_wait, ctl_beat, ctl_port;
    logic [AW-1:0] ctl_addr;
    int wb_port;
    logic [AW-1:0] wb_addr;
    int ctl_txns = 0;
    int dones = 0;
    int zero_run = 100;
    int cyc = 0;
    bit done_pend = 0;
    int done_due, done_port;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    function automatic logic [DW-1:0] ref_read(logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] ctl_read(logic [AW-1:0] a);
        return ctl_mem.exists(a) ? ctl_mem[a] : init_val(a);
    endfunction

    task automatic drive_ports();
        p0_req   = active[0];
        p0_we    = cur[0].we;
        p0_addr  = cur[0].addr;
        p0_wdata = (widx[0] < BL) ? cur[0].data[widx[0]] : '0;
        p1_req   = active[1];
        p1_we    = cur[1].we;
        p1_addr  = cur[1].addr;
        p1_wdata = (widx[1] < BL) ? cur[1].data[widx[1]] : '0;
    endtask

    task automatic issue(int n, logic we, logic [AW-1:0] a, logic [BL*DW-1:0] d);
        cur[n].we   = we;
        cur[n].addr = a;
        cur[n].data = d;
        active[n]   = 1;
        widx[n]     = 0;
        drive_ports();
    endtask

    // Just before the rising edge: the controller consumes write beats.
    task automatic pre_edge();
        if (mem_write_done) begin
            check("wnext_p0", p0_wnext, wb_port == 0);
            check("wnext_p1", p1_wnext, wb_port == 1);
            if (wr_q[wb_port].size() == 0) begin
                check("wdata_unexpected", 1, 0);
            end else begin
                check("wdata", mem_write_data, wr_q[wb_port].pop_front());
            end
            ctl_mem[wb_addr] = mem_write_data;
            wadv[wb_port] = 1;
        end else begin
            check("wnext_quiet", {p1_wnext, p0_wnext}, 0);
        end
    endtask

    // Just after the rising edge: monitor, controller model, requesters.
    task automatic step();
        bit r[2];
        bit started;
        int w;
        r[0] = p0_req;
        r[1] = p1_req;
        cyc++;
        for (int n = 0; n < 2; n++) begin
            logic rv = n ? p1_rvalid : p0_rvalid;
            logic [DW-1:0] rd = n ? p1_rdata : p0_rdata;
            logic dn = n ? p1_done : p0_done;
            logic exp_dn = done_pend && done_port == n && cyc == done_due;
            if (rv) begin
                if (rd_q[n].size() == 0) check("rvalid_unexpected", n, 99);
                else check("rdata", rd, rd_q[n].pop_front());
            end else begin
                check("rdata_quiet", rd, 0);
            end
            if (dn || exp_dn) check(n ? "p1_done" : "p0_done", dn, exp_dn);
            if (dn && active[n]) begin
                active[n] = 0;
                dones++;
            end
            if (wadv[n]) begin
                widx[n]++;
                wadv[n] = 0;
            end
        end
        if (done_pend && cyc >= done_due) done_pend = 0;

        if (mem_command == 2'd0) zero_run++;
        mem_read_valid = 0;
        mem_write_done = 0;
        mem_read_data  = '0;
        started = 0;
        if (!ctl_busy && mem_command != 2'd0) begin
            started = 1;
            ctl_txns++;
            check("gap_before_cmd", zero_run >= 2, 1);
            w = (r[1] && (!r[0] || starve_m >= SL)) ? 1 : 0;
            check("grant_has_req", r[w], 1);
            check("cmd", mem_command, cur[w].we ? 2'd1 : 2'd2);
            check("addr", mem_address, cur[w].addr);
            if (w == 1) starve_m = 0;
            else if (r[1] && starve_m < SL) starve_m++;
            grant_log.push_back(w);
            for (int i = 0; i < BL; i++) begin
                logic [AW-1:0] a = AW'(cur[w].addr + i);
                if (cur[w].we) begin
                    wr_q[w].push_back(cur[w].data[i]);
                    ref_mem[a] = cur[w].data[i];
                end else begin
                    rd_q[w].push_back(ref_read(a));
                end
            end
            ctl_busy = 1;
            ctl_we   = (mem_command == 2'd1);
            ctl_addr = mem_address;
            ctl_wait = $urandom_range(0, 2);
            ctl_beat = 0;
            ctl_port = w;
        end
        if (ctl_busy) begin
            if (!started) check("cmd_held", mem_command, ctl_we ? 2'd1 : 2'd2);
            if (ctl_wait > 0) begin
                ctl_wait--;
            end else begin
                if (ctl_we) begin
                    mem_write_done = 1;
                    wb_port = ctl_port;
                    wb_addr = AW'(ctl_addr + ctl_beat);
                end else begin
                    mem_read_valid = 1;
                    mem_read_data  = ctl_read(AW'(ctl_addr + ctl_beat));
                end
                ctl_beat++;
                if (ctl_beat == BL) begin
                    ctl_busy  = 0;
                    done_pend = 1;
                    done_due  = cyc + 1;
                    done_port = ctl_port;
                end
            end
        end
        if (mem_command != 2'd0) zero_run = 0;

        for (int n = 0; n < 2; n++) begin
            if (!active[n] && gen_left[n] > 0 && $urandom_range(0, 99) < gen_prob[n]) begin
                txn_t t;
                t.we   = 1'($urandom_range(0, 1));
                t.addr = (n ? 24'h800000 : 24'h000100) | AW'($urandom_range(0, 15) * 4);
                t.data = {$urandom, $urandom};
                cur[n] = t;
                active[n] = 1;
                widx[n] = 0;
                gen_left[n]--;
            end
        end
        drive_ports();
    endtask

    task automatic tick();
        @(negedge clk);
        #4;
        pre_edge();
        @(posedge clk);
        #1;
        step();
    endtask

    task automatic run_until_idle(int budget, string name);
        int k = 0;
        while ((active[0] || active[1] || ctl_busy || gen_left[0] > 0 || gen_left[1] > 0) && k < budget) begin
            tick();
            k++;
        end
        check({name, "_timeout"}, k < budget, 1);
    endtask

    task automatic check_quiet_outputs(string name);
        check({name, "_cmd"}, mem_command, 0);
        check({name, "_addr"}, mem_address, 0);
        check({name, "_flags"}, {p0_done, p0_rvalid, p0_wnext, p1_done, p1_rvalid, p1_wnext}, 0);
        check({name, "_rdata"}, {p0_rdata, p1_rdata}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int n = 0; n < 2; n++) begin
            cur[n] = '0; active[n] = 0; widx[n] = 0; wadv[n] = 0; gen_left[n] = 0; gen_prob[n] = 0;
        end
        drive_ports();
        mem_read_valid = 0; mem_write_done = 0; mem_read_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet_outputs("reset");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        step();
        tick();

        ref_mem[24'h000123] = 16'hBEEF;
        ctl_mem[24'h000123] = 16'hBEEF;
        issue(0, 1'b0, 24'h000123, '0);
        run_until_idle(200, "p0_read");
        issue(1, 1'b1, 24'h800040, {16'd4, 16'd3, 16'd2, 16'd1});
        run_until_idle(200, "p1_write");
        issue(1, 1'b0, 24'h800040, '0);
        run_until_idle(200, "p1_readback");

        grant_log.delete();
        gen_prob = '{100, 100};
        gen_left = '{12, 3};
        run_until_idle(2000, "both_busy");
        check("grant_count", grant_log.size(), 15);
        for (int i = 0; i < 15 && i < grant_log.size(); i++)
            check("grant_order", grant_log[i], (i % 5 == 4) ? 1 : 0);

        gen_prob = '{30, 30};
        gen_left = '{40, 40};
        run_until_idle(20000, "random");

        issue(0, 1'b0, 24'h000180, '0);
        issue(1, 1'b0, 24'h800080, '0);
        k = 0;
        while (!(ctl_busy && ctl_beat == 2) && k < 100) begin
            tick();
            k++;
        end
        check("mid_burst_timeout", k < 100, 1);
        check("mid_burst_port", ctl_port, 0);
        #2;
        rst_n = 0;
        #1;
        check("async_reset_cmd", mem_command, 0);
        check("async_reset_done", {p0_done, p1_done}, 0);
        for (int n = 0; n < 2; n++) begin
            active[n] = 0; widx[n] = 0; wadv[n] = 0;
            rd_q[n].delete(); wr_q[n].delete();
        end
        drive_ports();
        ctl_busy = 0; done_pend = 0; starve_m = 0; zero_run = 100;
        mem_read_valid = 0; mem_write_done = 0; mem_read_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        step();
        repeat (4) tick();

        grant_log.delete();
        gen_prob = '{100, 100};
        gen_left = '{8, 2};
        run_until_idle(2000, "after_reset");
        check("grant_count_rst", grant_log.size(), 10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            check("grant_order_rst", grant_log[i], (i % 5 == 4) ? 1 : 0);

        repeat (3) tick();
        check("ctl_txn_count", ctl_txns, dones + 1);
        check("rd_queue_empty", rd_q[0].size() + rd_q[1].size(), 0);
        check("wr_queue_empty", wr_q[0].size() + wr_q[1].size(), 0);
        check("final_cmd_idle", mem_command, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
